// File: rtl/rpn_pkg.sv
// Shared types for the RPN answer checker: token/operator encodings, error
// codes, FSM states and the unreduced rational {num, den} carried on the stack.
package rpn_pkg;

  localparam int NUM_W       = 20;
  localparam int DEN_W       = 16;
  localparam int STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    TOK_OPERAND  = 2'd0,
    TOK_OPERATOR = 2'd1,
    TOK_SUBMIT   = 2'd2,
    TOK_RSVD     = 2'd3
  } tok_kind_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_DUP        = 3'd1,
    ERR_UNDERFLOW  = 3'd2,
    ERR_DIVZ       = 3'd3,
    ERR_INCOMPLETE = 3'd4,
    ERR_OVERFLOW   = 3'd5
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [NUM_W-1:0] num;
    logic        [DEN_W-1:0] den;
  } rat_t;

endpackage

// File: rtl/rpn_answer_checker_rat_alu.sv
// Combinational exact-rational ALU: a op b without reduction, denominator kept
// positive, with divide-by-zero and range-overflow flags.
module rat_alu
  import rpn_pkg::*;
(
  input  rat_t        a_i,
  input  rat_t        b_i,
  input  op_e         op_i,
  output rat_t        res_o,
  output logic        divz_o,
  output logic        ovf_o
);

  localparam int WW = 40;
  localparam logic signed [WW-1:0] NUM_MAX = (40'sd1 <<< (NUM_W - 1)) - 40'sd1;
  localparam logic signed [WW-1:0] NUM_MIN = -(40'sd1 <<< (NUM_W - 1));
  localparam logic signed [WW-1:0] DEN_MAX = (40'sd1 <<< DEN_W) - 40'sd1;

  logic signed [WW-1:0] an, ad, bn, bd;
  logic signed [WW-1:0] rn, rd, rn_fix, rd_fix;

  // NOTE: combinational logic uses blocking '=' with every output given a
  // default up front, so no path leaves a value unassigned and infers a latch.
  always_comb begin
    an     = {{(WW-NUM_W){a_i.num[NUM_W-1]}}, a_i.num};
    bn     = {{(WW-NUM_W){b_i.num[NUM_W-1]}}, b_i.num};
    ad     = {{(WW-DEN_W){1'b0}}, a_i.den};
    bd     = {{(WW-DEN_W){1'b0}}, b_i.den};
    rn     = '0;
    rd     = '0;
    divz_o = 1'b0;

    unique case (op_i)
      OP_ADD: begin rn = an * bd + bn * ad; rd = ad * bd; end
      OP_SUB: begin rn = an * bd - bn * ad; rd = ad * bd; end
      OP_MUL: begin rn = an * bn;           rd = ad * bd; end
      OP_DIV: begin
        rn     = an * bd;
        rd     = ad * bn;
        divz_o = (bn == '0);
      end
    endcase

    // Division by a negative value flips the sign onto the denominator.
    if (rd < 0) begin
      rn_fix = -rn;
      rd_fix = -rd;
    end else begin
      rn_fix = rn;
      rd_fix = rd;
    end

    ovf_o     = !divz_o && ((rn_fix > NUM_MAX) || (rn_fix < NUM_MIN) || (rd_fix > DEN_MAX));
    res_o.num = rn_fix[NUM_W-1:0];
    res_o.den = rd_fix[DEN_W-1:0];
  end

endmodule

// File: rtl/rpn_answer_checker.sv
// Judges a player's RPN answer over the four latched puzzle numbers using exact
// rational arithmetic. Define RPN_TOP_OUT_EN to expose the running top/depth.
module rpn_answer_checker
  import rpn_pkg::*;
#(
  parameter int TARGET = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [3:0]              num1,
  input  logic [3:0]              num2,
  input  logic [3:0]              num3,
  input  logic [3:0]              num4,
  input  logic                    clear,
  input  logic                    tok_valid,
  input  logic [1:0]              tok_kind,
  input  logic [1:0]              tok_arg,
  output logic                    tok_ready,
  output logic                    done,
  output logic                    correct,
  output logic [2:0]              err
`ifdef RPN_TOP_OUT_EN
  ,
  output logic signed [NUM_W-1:0] top_num,
  output logic        [DEN_W-1:0] top_den,
  output logic        [2:0]       depth
`endif
);

  localparam int WW = 40;

  state_e          state_q, state_d;
  logic [3:0][3:0] nums_q, nums_d;
  logic [3:0]      used_q, used_d;
  logic [2:0]      depth_q, depth_d;
  rat_t            stack_q [STACK_DEPTH];
  rat_t            stack_d [STACK_DEPTH];
  err_e            err_q, err_d;
  logic            correct_q, correct_d;
  logic            done_q, done_d;

  logic [1:0]      idx_a, idx_b;
  op_e             alu_op;
  rat_t            alu_res;
  logic            alu_divz, alu_ovf;
  rat_t            push_val;
  err_e            fail;
  logic signed [WW-1:0] chk_lhs, chk_rhs;

  // Operands of an operator are the two entries just below the stack pointer.
  assign idx_b  = depth_q[1:0] - 2'd1;
  assign idx_a  = depth_q[1:0] - 2'd2;
  assign alu_op = op_e'(tok_arg);

  rat_alu u_alu (
    .a_i    (stack_q[idx_a]),
    .b_i    (stack_q[idx_b]),
    .op_i   (alu_op),
    .res_o  (alu_res),
    .divz_o (alu_divz),
    .ovf_o  (alu_ovf)
  );

  always_comb begin
    state_d   = state_q;
    nums_d    = nums_q;
    used_d    = used_q;
    depth_d   = depth_q;
    stack_d   = stack_q;
    err_d     = err_q;
    correct_d = correct_q;
    done_d    = 1'b0;
    fail      = ERR_NONE;

    push_val.num = {{(NUM_W-4){1'b0}}, nums_q[tok_arg]};
    push_val.den = {{(DEN_W-1){1'b0}}, 1'b1};
    chk_lhs      = {{(WW-NUM_W){stack_q[0].num[NUM_W-1]}}, stack_q[0].num};
    chk_rhs      = WW'(TARGET) * $signed({{(WW-DEN_W){1'b0}}, stack_q[0].den});

    if (load) begin
      nums_d    = {num4, num3, num2, num1};
      used_d    = '0;
      depth_d   = '0;
      err_d     = ERR_NONE;
      correct_d = 1'b0;
      state_d   = ST_ENTRY;
    end else if (clear && (state_q != ST_IDLE)) begin
      used_d    = '0;
      depth_d   = '0;
      err_d     = ERR_NONE;
      correct_d = 1'b0;
      state_d   = ST_ENTRY;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ENTRY: begin
          if (tok_valid) begin
            unique case (tok_kind_e'(tok_kind))
              TOK_OPERAND: begin
                if (used_q[tok_arg])                    fail = ERR_DUP;
                else if (depth_q == 3'(STACK_DEPTH))    fail = ERR_OVERFLOW;
                else begin
                  stack_d[depth_q[1:0]] = push_val;
                  depth_d               = depth_q + 3'd1;
                  used_d[tok_arg]       = 1'b1;
                end
              end
              TOK_OPERATOR: begin
                if (depth_q < 3'd2)  fail = ERR_UNDERFLOW;
                else if (alu_divz)   fail = ERR_DIVZ;
                else if (alu_ovf)    fail = ERR_OVERFLOW;
                else begin
                  stack_d[idx_a] = alu_res;
                  depth_d        = depth_q - 3'd1;
                end
              end
              TOK_SUBMIT: begin
                if ((used_q != 4'hF) || (depth_q != 3'd1)) fail = ERR_INCOMPLETE;
                else                                       state_d = ST_CHECK;
              end
              default: ;
            endcase
          end
          if (fail != ERR_NONE) begin
            err_d     = fail;
            correct_d = 1'b0;
            state_d   = ST_RESULT;
            done_d    = 1'b1;
          end
        end
        ST_CHECK: begin
          // Cross-multiplied compare: num/den == TARGET without reducing.
          correct_d = (chk_lhs == chk_rhs);
          state_d   = ST_RESULT;
          done_d    = 1'b1;
        end
        ST_RESULT: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      nums_q    <= '0;
      used_q    <= '0;
      depth_q   <= '0;
      err_q     <= ERR_NONE;
      correct_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nums_q    <= nums_d;
      used_q    <= used_d;
      depth_q   <= depth_d;
      err_q     <= err_d;
      correct_q <= correct_d;
      done_q    <= done_d;
    end
  end

  // NOTE: stack payload is deliberately not reset; depth_q alone marks which
  // entries are valid, so the storage needs no reset wiring.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign tok_ready = (state_q == ST_ENTRY);
  assign done      = done_q;
  assign correct   = correct_q;
  assign err       = err_q;

`ifdef RPN_TOP_OUT_EN
  logic signed [NUM_W-1:0] top_num_q;
  logic        [DEN_W-1:0] top_den_q;
  logic        [2:0]       depth_q2;

  always_ff @(posedge clk) begin
    if (rst || (depth_d == 3'd0)) begin
      top_num_q <= '0;
      top_den_q <= '0;
      depth_q2  <= '0;
    end else begin
      top_num_q <= stack_d[depth_d[1:0] - 2'd1].num;
      top_den_q <= stack_d[depth_d[1:0] - 2'd1].den;
      depth_q2  <= depth_d;
    end
  end

  assign top_num = top_num_q;
  assign top_den = top_den_q;
  assign depth   = depth_q2;
`endif

endmodule

// File: tb/tb_rpn_answer_checker.sv
// Self-checking bench for rpn_answer_checker: directed puzzles plus random RPN
// answers judged by a queue-based rational evaluator.
module tb_rpn_answer_checker;

  logic        clk = 1'b0;
  logic        rst, load, clear, tok_valid;
  logic [3:0]  num1, num2, num3, num4;
  logic [1:0]  tok_kind, tok_arg;
  logic        tok_ready, done, correct;
  logic [2:0]  err;
`ifdef RPN_TOP_OUT_EN
  logic signed [19:0] top_num;
  logic        [15:0] top_den;
  logic        [2:0]  depth;
`endif

  rpn_answer_checker dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .num1      (num1),
    .num2      (num2),
    .num3      (num3),
    .num4      (num4),
    .clear     (clear),
    .tok_valid (tok_valid),
    .tok_kind  (tok_kind),
    .tok_arg   (tok_arg),
    .tok_ready (tok_ready),
    .done      (done),
    .correct   (correct),
    .err       (err)
`ifdef RPN_TOP_OUT_EN
    ,
    .top_num   (top_num),
    .top_den   (top_den),
    .depth     (depth)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] arg;
  } tok_t;

  localparam int ADD = 0, SUB = 1, MUL = 2, DIV = 3;
  localparam int E_NONE = 0, E_DUP = 1, E_UNDER = 2, E_DIVZ = 3, E_INCOMP = 4, E_OVF = 5;

  int n_tests = 0;
  int n_fail  = 0;
  int cur [4];

  function automatic tok_t S(int slot);
    tok_t t;
    t.kind = 2'd0;
    t.arg  = 2'(slot);
    return t;
  endfunction

  function automatic tok_t O(int op);
    tok_t t;
    t.kind = 2'd1;
    t.arg  = 2'(op);
    return t;
  endfunction

  function automatic tok_t SUBMIT();
    tok_t t;
    t.kind = 2'd2;
    t.arg  = 2'd0;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int a, input int b, input int c, input int d);
    num1 = 4'(a); num2 = 4'(b); num3 = 4'(c); num4 = 4'(d);
    load = 1'b1;
    tick();
    load = 1'b0;
    cur[0] = a; cur[1] = b; cur[2] = c; cur[3] = d;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Evaluates the answer as a game judge would: exact fractions, first fault
  // wins. at = cycle (1-based from the first token) on which done is expected.
  function automatic void model(input int nums [4], input tok_t q [$],
                                output bit has_res, output int exp_err,
                                output bit exp_ok, output int at);
    longint sn [$];
    longint sd [$];
    longint an, ad, bn, bd, rn, rd;
    int     used;
    has_res = 1'b0; exp_err = E_NONE; exp_ok = 1'b0; at = 0; used = 0;
    foreach (q[i]) begin
      if (q[i].kind == 2'd0) begin
        if (((used >> q[i].arg) & 1) != 0) begin
          has_res = 1'b1; exp_err = E_DUP; at = i + 1; return;
        end
        if (sn.size() >= 4) begin
          has_res = 1'b1; exp_err = E_OVF; at = i + 1; return;
        end
        sn.push_back(longint'(nums[q[i].arg]));
        sd.push_back(1);
        used = used | (1 << q[i].arg);
      end else if (q[i].kind == 2'd1) begin
        if (sn.size() < 2) begin
          has_res = 1'b1; exp_err = E_UNDER; at = i + 1; return;
        end
        bn = sn.pop_back(); bd = sd.pop_back();
        an = sn.pop_back(); ad = sd.pop_back();
        case (int'(q[i].arg))
          ADD:     begin rn = an * bd + bn * ad; rd = ad * bd; end
          SUB:     begin rn = an * bd - bn * ad; rd = ad * bd; end
          MUL:     begin rn = an * bn;           rd = ad * bd; end
          default: begin
            if (bn == 0) begin
              has_res = 1'b1; exp_err = E_DIVZ; at = i + 1; return;
            end
            rn = an * bd; rd = ad * bn;
          end
        endcase
        if (rd < 0) begin rn = -rn; rd = -rd; end
        if (rn > 524287 || rn < -524288 || rd > 65535) begin
          has_res = 1'b1; exp_err = E_OVF; at = i + 1; return;
        end
        sn.push_back(rn);
        sd.push_back(rd);
      end else if (q[i].kind == 2'd2) begin
        if (used != 15 || sn.size() != 1) begin
          has_res = 1'b1; exp_err = E_INCOMP; at = i + 1; return;
        end
        has_res = 1'b1; exp_ok = (sn[0] == 24 * sd[0]); at = i + 2; return;
      end
    end
  endfunction

  // Streams one token per cycle, then idles a few cycles, counting done pulses.
  task automatic play(input string name, input tok_t q [$]);
    bit has_res, exp_ok;
    int exp_err, exp_at, done_cnt, done_at;
    model(cur, q, has_res, exp_err, exp_ok, exp_at);
    done_cnt = 0;
    done_at  = 0;
    for (int i = 0; i < q.size(); i++) begin
      tok_valid = 1'b1;
      tok_kind  = q[i].kind;
      tok_arg   = q[i].arg;
      tick();
      if (done === 1'b1) begin done_cnt++; done_at = i + 1; end
    end
    tok_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      if (done === 1'b1) begin done_cnt++; done_at = q.size() + j; end
    end
    if (has_res) begin
      check({name, ".done_cnt"}, 64'(done_cnt), 64'(1));
      check({name, ".done_at"},  64'(done_at),  64'(exp_at));
      check({name, ".err"},      64'(err),      64'(exp_err));
      check({name, ".correct"},  64'(correct),  64'(exp_ok));
      check({name, ".tok_ready"}, 64'(tok_ready), 64'(0));
    end else begin
      check({name, ".no_done"},   64'(done_cnt),  64'(0));
      check({name, ".tok_ready"}, 64'(tok_ready), 64'(1));
      check({name, ".err"},       64'(err),       64'(E_NONE));
    end
  endtask

  initial begin
    string pats [5];
    tok_t  q [$];
    int    n [4];
    int    perm [4];
    int    k, tmp, sel;
    pats[0] = "nnonono"; pats[1] = "nnonnoo"; pats[2] = "nnnoono";
    pats[3] = "nnnonoo"; pats[4] = "nnnnooo";

    rst = 1'b1; load = 1'b0; clear = 1'b0; tok_valid = 1'b0;
    tok_kind = 2'd0; tok_arg = 2'd0;
    num1 = 4'd0; num2 = 4'd0; num3 = 4'd0; num4 = 4'd0;
    cur[0] = 0; cur[1] = 0; cur[2] = 0; cur[3] = 0;
    tick();
    tick();
    rst = 1'b0;
    check("reset.tok_ready", 64'(tok_ready), 64'(0));
    check("reset.done",      64'(done),      64'(0));
    check("reset.correct",   64'(correct),   64'(0));
    check("reset.err",       64'(err),       64'(0));

    // IDLE ignores tokens and clear.
    tok_valid = 1'b1; tok_kind = 2'd0; tok_arg = 2'd0;
    tick();
    tok_valid = 1'b0;
    check("idle.token_ignored", 64'(tok_ready), 64'(0));
    do_clear();
    check("idle.clear_ignored", 64'(tok_ready), 64'(0));
    check("idle.clear_no_done", 64'(done),      64'(0));

    // (11-8)*4*2
    do_load(2, 4, 8, 11);
    check("load.tok_ready", 64'(tok_ready), 64'(1));
    play("p2_4_8_11", '{S(3), S(2), O(SUB), S(1), O(MUL), S(0), O(MUL), SUBMIT()});
    check("p2_4_8_11.correct_abs", 64'(correct), 64'(1));

    // 8/(3-8/3), only right with exact fractions.
    do_load(3, 3, 8, 8);
    play("p3_3_8_8", '{S(2), S(0), S(3), S(1), O(DIV), O(SUB), O(DIV), SUBMIT()});
    check("p3_3_8_8.correct_abs", 64'(correct), 64'(1));
`ifdef RPN_TOP_OUT_EN
    check("p3_3_8_8.top_num", 64'(top_num), 64'(24));
    check("p3_3_8_8.top_den", 64'(top_den), 64'(1));
    check("p3_3_8_8.depth",   64'(depth),   64'(1));
`endif

    // 8/(3-3): divide by zero, later tokens dropped.
    do_load(3, 3, 8, 8);
    play("divz", '{S(2), S(0), S(1), O(SUB), O(DIV), S(3), O(ADD), SUBMIT()});
    check("divz.err_abs", 64'(err), 64'(E_DIVZ));
    do_clear();
    check("divz.clear_ready", 64'(tok_ready), 64'(1));
    check("divz.clear_err",   64'(err),       64'(0));

    do_load(1, 1, 1, 1);
    play("dup", '{S(0), S(0)});
    do_clear();
    play("underflow", '{S(0), O(ADD)});
    do_clear();
    play("incomplete", '{S(0), S(1), O(ADD), SUBMIT()});
    do_clear();
    play("sum4", '{S(0), S(1), O(ADD), S(2), O(ADD), S(3), O(ADD), SUBMIT()});

    // Reset from RESULT holding correct=1, and reset mid-entry.
    do_load(6, 4, 1, 1);
    play("pre_rst", '{S(0), S(1), O(MUL), S(2), O(MUL), S(3), O(MUL), SUBMIT()});
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_result.correct",   64'(correct),   64'(0));
    check("rst_result.tok_ready", 64'(tok_ready), 64'(0));
    do_load(1, 2, 3, 4);
    play("partial", '{S(0), S(1)});
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_entry.tok_ready", 64'(tok_ready), 64'(0));
    check("rst_entry.done",      64'(done),      64'(0));
    check("rst_entry.correct",   64'(correct),   64'(0));
    check("rst_entry.err",       64'(err),       64'(0));
`ifdef RPN_TOP_OUT_EN
    check("rst_entry.depth",     64'(depth),     64'(0));
`endif

    // load and clear together: load wins, new numbers latched.
    do_load(1, 1, 1, 1);
    play("pre_prio", '{S(0)});
    num1 = 4'd6; num2 = 4'd4; num3 = 4'd1; num4 = 4'd1;
    load = 1'b1; clear = 1'b1;
    tick();
    load = 1'b0; clear = 1'b0;
    cur[0] = 6; cur[1] = 4; cur[2] = 1; cur[3] = 1;
    play("prio", '{S(0), S(1), O(MUL), S(2), O(MUL), S(3), O(MUL), SUBMIT()});
    check("prio.correct_abs", 64'(correct), 64'(1));

    // Random well-formed answers, some mutated or left unsubmitted.
    for (int it = 0; it < 60; it++) begin
      for (int s = 0; s < 4; s++) begin
        n[s]    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 13));
        perm[s] = s;
      end
      for (int s = 3; s > 0; s--) begin
        k = int'($urandom_range(0, s));
        tmp = perm[s]; perm[s] = perm[k]; perm[k] = tmp;
      end
      do_load(n[0], n[1], n[2], n[3]);
      q.delete();
      sel = int'($urandom_range(0, 4));
      k = 0;
      for (int c = 0; c < pats[sel].len(); c++) begin
        if (pats[sel][c] == "n") begin
          q.push_back(S(perm[k]));
          k++;
        end else begin
          q.push_back(O(int'($urandom_range(0, 3))));
        end
      end
      if ($urandom_range(0, 5) != 0) q.push_back(SUBMIT());
      if ($urandom_range(0, 3) == 0) q[$urandom_range(0, q.size() - 1)] = tok_t'($urandom_range(0, 15));
      play($sformatf("rand%0d", it), q);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
